mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_req_arbiter_if.sv | 53 +++++
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_req_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and line-size constants for the two-client memory arbiter.
// Imported by the arbiter top and its round-robin selector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef logic client_id_t;

  localparam int LINE_BYTES = 64;
  localparam int LINE_BITS  = 8 * LINE_BYTES;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Client and memory-server signals of the arbiter.
// master: arbiter side; slave: clients plus server.
interface mem_req_arbiter_if #(
  parameter int ADDR_W    = 64,
  parameter int LINE_BITS = mem_arb_pkg::LINE_BITS
);

  logic                 c0_req;
  logic [ADDR_W-1:0]    c0_addr;
  logic                 c0_done;
  logic [LINE_BITS-1:0] c0_buf;
  logic [6:0]           c0_offset;
  logic [6:0]           c0_num_bytes;

  logic                 c1_req;
  logic [ADDR_W-1:0]    c1_addr;
  logic                 c1_done;
  logic [LINE_BITS-1:0] c1_buf;
  logic [6:0]           c1_offset;
  logic [6:0]           c1_num_bytes;

  logic [ADDR_W-1:0]    mem_fetch_ad;
  logic                 mem_send_fetch_req;
  logic [LINE_BITS-1:0] mem_buffer;
  logic                 mem_req_completed;
  logic [6:0]           mem_buf_offset;
  logic [6:0]           mem_num_bytes;

  logic                 err_timeout;

  modport master (
    input  c0_req, c0_addr,
    input  c1_req, c1_addr,
    output c0_done, c0_buf, c0_offset, c0_num_bytes,
    output c1_done, c1_buf, c1_offset, c1_num_bytes,
    output mem_fetch_ad, mem_send_fetch_req,
    input  mem_buffer, mem_req_completed,
    input  mem_buf_offset, mem_num_bytes,
    output err_timeout
  );

  modport slave (
    output c0_req, c0_addr,
    output c1_req, c1_addr,
    input  c0_done, c0_buf, c0_offset, c0_num_bytes,
    input  c1_done, c1_buf, c1_offset, c1_num_bytes,
    input  mem_fetch_ad, mem_send_fetch_req,
    output mem_buffer, mem_req_completed,
    output mem_buf_offset, mem_num_bytes,
    input  err_timeout
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; last names the client granted previously.
// On a tie the other client wins, so last=1 favours client 0.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  client_id_t last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req[0] & req[1]):  gnt = last ? 2'b01 : 2'b10;
      (req[0] & ~req[1]): gnt = 2'b01;
      (~req[0] & req[1]): gnt = 2'b10;
      default:            gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory fetch server between two clients, round-robin,
// with per-client response capture and a sticky BUSY timeout flag.
module mem_req_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = mem_arb_pkg::LINE_BYTES,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.master bus
);

  import mem_arb_pkg::*;

  localparam int LBITS = 8 * LINE_BYTES;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  client_id_t          own_q, own_d;
  client_id_t          last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic [ADDR_W-1:0]   ad_q, ad_d;
  logic [LBITS-1:0]    buf_q [2];
  logic [LBITS-1:0]    buf_d [2];
  logic [6:0]          off_q [2];
  logic [6:0]          off_d [2];
  logic [6:0]          nb_q [2];
  logic [6:0]          nb_d [2];
  logic                err_q, err_d;
  logic [1:0]          gnt;

  rr_arb2 u_rr (
    .req  ({bus.c1_req, bus.c0_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ad_d    = ad_q;
    buf_d   = buf_q;
    off_d   = off_q;
    nb_d    = nb_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          own_d   = gnt[1];
          ad_d    = gnt[1] ? bus.c1_addr : bus.c0_addr;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // completion wins over a timeout landing on the same cycle
        if (bus.mem_req_completed) begin
          buf_d[own_q] = bus.mem_buffer;
          off_d[own_q] = bus.mem_buf_offset;
          nb_d[own_q]  = bus.mem_num_bytes;
          state_d      = RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          nb_d[own_q] = '0;
          err_d       = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      ad_q     <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      off_q[0] <= '0;
      off_q[1] <= '0;
      nb_q[0]  <= '0;
      nb_q[1]  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ad_q    <= ad_d;
      buf_q   <= buf_d;
      off_q   <= off_d;
      nb_q    <= nb_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_send_fetch_req = (state_q == BUSY);
  assign bus.mem_fetch_ad       = ad_q;
  assign bus.err_timeout        = err_q;

  assign bus.c0_done      = (state_q == RESP) && (own_q == 1'b0);
  assign bus.c0_buf       = buf_q[0];
  assign bus.c0_offset    = off_q[0];
  assign bus.c0_num_bytes = nb_q[0];

  assign bus.c1_done      = (state_q == RESP) && (own_q == 1'b1);
  assign bus.c1_buf       = buf_q[1];
  assign bus.c1_offset    = off_q[1];
  assign bus.c1_num_bytes = nb_q[1];

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: transaction-level reference model compared
// every cycle, directed corner scenarios, then randomized traffic.
module tb_mem_req_arbiter;

  localparam int AW  = 64;
  localparam int LB  = 512;
  localparam int TMO = 1023;

  logic clk;
  logic rst_n;
  logic cmp_en;

  int vectors;
  int miscompares;

  mem_req_arbiter_if #(.ADDR_W(AW), .LINE_BITS(LB)) bus ();

  mem_req_arbiter #(
    .ADDR_W     (AW),
    .LINE_BYTES (LB / 8),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: idle / fetching / responding, per-client result store
  int          m_mode;
  int          m_own;
  int          m_last;
  int          m_age;
  logic [AW-1:0] m_ad;
  logic [LB-1:0] m_buf [2];
  logic [6:0]  m_off [2];
  logic [6:0]  m_nb [2];
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_own = 0; m_last = 1; m_age = 0;
      m_ad = '0; m_err = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_buf[i] = '0; m_off[i] = '0; m_nb[i] = '0;
      end
    end else begin
      case (m_mode)
        0: begin
          if (bus.c0_req || bus.c1_req) begin
            if (bus.c0_req && bus.c1_req) m_own = (m_last == 0) ? 1 : 0;
            else m_own = bus.c0_req ? 0 : 1;
            m_ad = (m_own == 1) ? bus.c1_addr : bus.c0_addr;
            m_age = 0;
            m_mode = 1;
          end
        end
        1: begin
          if (bus.mem_req_completed) begin
            m_buf[m_own] = bus.mem_buffer;
            m_off[m_own] = bus.mem_buf_offset;
            m_nb[m_own] = bus.mem_num_bytes;
            m_mode = 2;
          end else if (m_age + 1 == TMO) begin
            m_nb[m_own] = '0;
            m_err = 1'b1;
            m_mode = 2;
          end else begin
            m_age++;
          end
        end
        default: begin
          m_last = m_own;
          m_mode = 0;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkl(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("send_req", 64'(bus.mem_send_fetch_req), 64'(m_mode == 1));
      chk("fetch_ad", bus.mem_fetch_ad, m_ad);
      chk("err_timeout", 64'(bus.err_timeout), 64'(m_err));
      chk("c0_done", 64'(bus.c0_done), 64'(m_mode == 2 && m_own == 0));
      chk("c1_done", 64'(bus.c1_done), 64'(m_mode == 2 && m_own == 1));
      chk("c0_offset", 64'(bus.c0_offset), 64'(m_off[0]));
      chk("c1_offset", 64'(bus.c1_offset), 64'(m_off[1]));
      chk("c0_num_bytes", 64'(bus.c0_num_bytes), 64'(m_nb[0]));
      chk("c1_num_bytes", 64'(bus.c1_num_bytes), 64'(m_nb[1]));
      chkl("c0_buf", bus.c0_buf, m_buf[0]);
      chkl("c1_buf", bus.c1_buf, m_buf[1]);
    end
  end

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] v;
    v = '0;
    for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_send"}, 64'(bus.mem_send_fetch_req), 64'd0);
    chk({tag, "_ad"}, bus.mem_fetch_ad, 64'd0);
    chk({tag, "_err"}, 64'(bus.err_timeout), 64'd0);
    chk({tag, "_done0"}, 64'(bus.c0_done), 64'd0);
    chk({tag, "_done1"}, 64'(bus.c1_done), 64'd0);
    chk({tag, "_nb0"}, 64'(bus.c0_num_bytes), 64'd0);
    chk({tag, "_nb1"}, 64'(bus.c1_num_bytes), 64'd0);
    chk({tag, "_off0"}, 64'(bus.c0_offset), 64'd0);
    chk({tag, "_off1"}, 64'(bus.c1_offset), 64'd0);
    chkl({tag, "_buf0"}, bus.c0_buf, '0);
    chkl({tag, "_buf1"}, bus.c1_buf, '0);
  endtask

  task automatic clr_inputs();
    bus.c0_req = 1'b0; bus.c0_addr = '0;
    bus.c1_req = 1'b0; bus.c1_addr = '0;
    bus.mem_buffer = '0; bus.mem_req_completed = 1'b0;
    bus.mem_buf_offset = '0; bus.mem_num_bytes = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rst_n = 1'b0;
    clr_inputs();
    #1;
    chk_zero(tag);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // serves one transaction; dly = BUSY cycle carrying the completion, 0 = never
  task automatic run_txn(input int dly, input logic [6:0] nb, input logic [6:0] off,
                         output int nbusy, output int who);
    int guard;
    nbusy = 0; who = -1; guard = 0;
    while (who < 0 && guard < TMO + 50) begin
      @(negedge clk); #1;
      guard++;
      bus.mem_req_completed = 1'b0;
      if (bus.c0_done) begin
        who = 0; bus.c0_req = 1'b0;
      end else if (bus.c1_done) begin
        who = 1; bus.c1_req = 1'b0;
      end else if (bus.mem_send_fetch_req) begin
        nbusy++;
        if (nbusy == dly) begin
          bus.mem_req_completed = 1'b1;
          bus.mem_buffer = rnd_line();
          bus.mem_buf_offset = off;
          bus.mem_num_bytes = nb;
        end
      end
    end
    bus.mem_req_completed = 1'b0;
    if (who < 0) chk("txn_no_done", 64'd0, 64'd1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbsy, who, dn;
    logic [6:0] keep_nb;
    vectors = 0; miscompares = 0;
    cmp_en = 1'b1;
    rst_n = 1'b0;
    clr_inputs();

    // single request, completion on the 5th BUSY cycle
    do_reset("rst0");
    bus.c0_addr = 64'h1000; bus.c0_req = 1'b1;
    run_txn(5, 7'd64, 7'd0, nbsy, who);
    chk("t040_busy_cycles", 64'(nbsy), 64'd5);
    chk("t040_who", 64'(who), 64'd0);
    chk("t040_ad", bus.mem_fetch_ad, 64'h1000);
    chk("t040_nb", 64'(bus.c0_num_bytes), 64'd64);
    @(negedge clk); #1;
    chk("t040_done_once", 64'(bus.c0_done), 64'd0);

    // simultaneous pairs: 0, 1, then 0 again
    do_reset("rst1");
    bus.c0_addr = 64'h1000; bus.c1_addr = 64'h2000;
    bus.c0_req = 1'b1; bus.c1_req = 1'b1;
    run_txn(3, 7'd16, 7'd2, nbsy, who);
    chk("t041_first", 64'(who), 64'd0);
    chk("t041_ad0", bus.mem_fetch_ad, 64'h1000);
    run_txn(2, 7'd8, 7'd4, nbsy, who);
    chk("t041_second", 64'(who), 64'd1);
    chk("t041_ad1", bus.mem_fetch_ad, 64'h2000);
    chk("t041_nb1", 64'(bus.c1_num_bytes), 64'd8);
    bus.c0_req = 1'b1; bus.c1_req = 1'b1;
    run_txn(4, 7'd1, 7'd1, nbsy, who);
    chk("t041_third", 64'(who), 64'd0);
    run_txn(4, 7'd2, 7'd3, nbsy, who);
    chk("t041_fourth", 64'(who), 64'd1);

    // server never answers
    do_reset("rst2");
    bus.c0_addr = 64'h3000; bus.c0_req = 1'b1;
    run_txn(2, 7'd33, 7'd9, nbsy, who);
    bus.c0_req = 1'b1;
    run_txn(0, 7'd0, 7'd0, nbsy, who);
    chk("t042_busy_cycles", 64'(nbsy), 64'd1023);
    chk("t042_who", 64'(who), 64'd0);
    chk("t042_err", 64'(bus.err_timeout), 64'd1);
    chk("t042_nb", 64'(bus.c0_num_bytes), 64'd0);
    chk("t042_off_kept", 64'(bus.c0_offset), 64'd9);
    bus.c0_req = 1'b1;
    run_txn(3, 7'd10, 7'd1, nbsy, who);
    chk("t042_next_busy", 64'(nbsy), 64'd3);
    chk("t042_next_nb", 64'(bus.c0_num_bytes), 64'd10);
    chk("t042_err_sticky", 64'(bus.err_timeout), 64'd1);

    // reset in the middle of a fetch
    bus.c1_addr = 64'h4000; bus.c1_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t044_busy", 64'(bus.mem_send_fetch_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("t044");
    bus.c1_req = 1'b0;
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.c0_done || bus.c1_done) dn++;
    end
    chk("t044_no_done", 64'(dn), 64'd0);
    #1;
    rst_n = 1'b1;
    bus.c0_addr = 64'h5000; bus.c1_addr = 64'h6000;
    bus.c0_req = 1'b1; bus.c1_req = 1'b1;
    run_txn(2, 7'd5, 7'd5, nbsy, who);
    chk("t044_prio0", 64'(who), 64'd0);
    run_txn(2, 7'd6, 7'd6, nbsy, who);

    // completion together with the timeout
    do_reset("rst3");
    bus.c0_addr = 64'h7000; bus.c0_req = 1'b1;
    run_txn(TMO, 7'd20, 7'd5, nbsy, who);
    chk("t043_busy_cycles", 64'(nbsy), 64'd1023);
    chk("t043_err", 64'(bus.err_timeout), 64'd0);
    chk("t043_nb", 64'(bus.c0_num_bytes), 64'd20);
    chk("t043_off", 64'(bus.c0_offset), 64'd5);

    // stray completion while idle
    @(negedge clk); #1;
    keep_nb = bus.c0_num_bytes;
    dn = 0;
    repeat (3) begin
      bus.mem_req_completed = 1'b1;
      bus.mem_num_bytes = 7'd99;
      bus.mem_buf_offset = 7'd77;
      @(negedge clk);
      if (bus.c0_done || bus.c1_done) dn++;
      #1;
    end
    bus.mem_req_completed = 1'b0;
    chk("t045_no_done", 64'(dn), 64'd0);
    chk("t045_nb_kept", 64'(bus.c0_num_bytes), 64'(keep_nb));
    chk("t045_nb_lit", 64'(bus.c0_num_bytes), 64'd20);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk); #1;
      bus.mem_req_completed = ($urandom_range(0, 3) == 0);
      bus.mem_buffer = rnd_line();
      bus.mem_buf_offset = 7'($urandom);
      bus.mem_num_bytes = 7'($urandom);
      if (bus.c0_done) bus.c0_req = 1'b0;
      else if (!bus.c0_req && $urandom_range(0, 3) == 0) begin
        bus.c0_addr = {$urandom, $urandom}; bus.c0_req = 1'b1;
      end else if (bus.c0_req && bus.mem_send_fetch_req && $urandom_range(0, 15) == 0)
        bus.c0_req = 1'b0;
      if (bus.c1_done) bus.c1_req = 1'b0;
      else if (!bus.c1_req && $urandom_range(0, 3) == 0) begin
        bus.c1_addr = {$urandom, $urandom}; bus.c1_req = 1'b1;
      end else if (bus.c1_req && bus.mem_send_fetch_req && $urandom_range(0, 15) == 0)
        bus.c1_req = 1'b0;
    end
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
